// File: rtl/wide_add_sequencer_if.sv
// Request/result bus for wide_add_sequencer: requester-side valid/ready with
// operands, and consumer-side valid/ready with the W-bit result and flags.
interface wide_add_sequencer_if #(
   parameter int WORDS = 4
);
   localparam int W = 16 * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic         in_sub;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         busy;

   modport master (
      output in_valid, in_sub, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );

   modport slave (
      input  in_valid, in_sub, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide adder/subtractor that walks one 16-bit carry-select slice across WORDS
// operand words, LSW first, chaining the carry through a register.
module wide_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   wide_add_sequencer_if.slave  bus
);
   localparam int W     = 16 * WORDS;
   localparam int IDX_W = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   state_t             nextState;
   logic [W-1:0]       aReg;
   logic [W-1:0]       bReg;
   logic [W-1:0]       sumReg;
   logic               carryReg;
   logic               coutReg;
   logic               ovfReg;
   logic [IDX_W-1:0]   wordIdx;
   logic               lastWord;
   logic               accept;

   logic [15:0]        sliceA;
   logic [15:0]        sliceB;
   logic [15:0]        sliceS;
   logic               sliceCout;
   logic [8:0]         loSum;
   logic [8:0]         hiSum0;
   logic [8:0]         hiSum1;

   assign lastWord = (wordIdx == IDX_W'(WORDS - 1));
   assign accept   = (state == IDLE) && bus.in_valid;
   assign sliceA   = aReg[{wordIdx, 4'b0000} +: 16];
   assign sliceB   = bReg[{wordIdx, 4'b0000} +: 16];

   // The only arithmetic in the block: a 16-bit carry-select slice whose upper
   // byte is precomputed for both possible carries out of the lower byte.
   always_comb begin
      loSum     = {1'b0, sliceA[7:0]} + {1'b0, sliceB[7:0]} + {8'd0, carryReg};
      hiSum0    = {1'b0, sliceA[15:8]} + {1'b0, sliceB[15:8]};
      hiSum1    = {1'b0, sliceA[15:8]} + {1'b0, sliceB[15:8]} + 9'd1;
      sliceS    = {(loSum[8] ? hiSum1[7:0] : hiSum0[7:0]), loSum[7:0]};
      sliceCout = loSum[8] ? hiSum1[8] : hiSum0[8];
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values;
   // blocking = here would let later statements see already-updated state.
   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= IDLE;
      else          state <= nextState;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      nextState     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) nextState = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (lastWord) nextState = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.busy      = 1'b1;
            if (bus.out_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // NOTE: operand registers carry no reset; they are always loaded on
   // acceptance before being read, so resetting them would only add logic.
   always_ff @(posedge Clk) begin
      if (accept) begin
         aReg <= bus.in_a;
         bReg <= bus.in_b ^ {W{bus.in_sub}};
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         wordIdx  <= '0;
         carryReg <= 1'b0;
         sumReg   <= '0;
         coutReg  <= 1'b0;
         ovfReg   <= 1'b0;
      end else if (accept) begin
         // Subtract enters as A + ~B with the +1 supplied as the first carry.
         wordIdx  <= '0;
         carryReg <= bus.in_sub;
         sumReg   <= '0;
         coutReg  <= 1'b0;
         ovfReg   <= 1'b0;
      end else if (state == RUN) begin
         sumReg[{wordIdx, 4'b0000} +: 16] <= sliceS;
         carryReg <= sliceCout;
         if (lastWord) begin
            coutReg <= sliceCout;
            ovfReg  <= (aReg[W-1] == bReg[W-1]) & (sliceS[15] != aReg[W-1]);
         end else begin
            wordIdx <= wordIdx + IDX_W'(1);
         end
      end
   end

   assign bus.out_sum  = sumReg;
   assign bus.out_cout = coutReg;
   assign bus.out_ovf  = ovfReg;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed vectors with literal
// expectations plus a full-width reference model checked every cycle.
module tb_wide_add_sequencer;
   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   wide_add_sequencer_if #(.WORDS(WORDS)) bus ();
   wide_add_sequencer #(.WORDS(WORDS)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

   int nVec  = 0;
   int nFail = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           due;
   } res_t;

   res_t         pend[$];
   logic [W-1:0] heldSum;
   logic         heldCout;
   logic         heldOvf;
   bit           armed = 1'b0;
   bit           mIdle;
   bit           mDue;
   int           cyc = 0;

   // Full-width arithmetic: unsigned compare for the borrow, sign-extended
   // math for overflow.
   function automatic res_t reference(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input int due);
      res_t             r;
      logic [W:0]       wide;
      logic signed [W:0] sa, sb, sr;
      sa = $signed({a[W-1], a});
      sb = $signed({b[W-1], b});
      sr = sub ? (sa - sb) : (sa + sb);
      wide = {1'b0, a} + {1'b0, b};
      r.sum  = sub ? (a - b) : (a + b);
      r.cout = sub ? (a >= b) : wide[W];
      r.ovf  = sr[W] ^ sr[W-1];
      r.due  = due;
      return r;
   endfunction

   // Model update: tracks accepted requests and consumer handshakes.
   always @(posedge Clk) begin
      if (!Reset_n) begin
         pend.delete();
         heldSum  = '0;
         heldCout = 1'b0;
         heldOvf  = 1'b0;
         armed    = 1'b1;
      end else if (armed) begin
         if (pend.size() == 0) begin
            if (bus.in_valid)
               pend.push_back(reference(bus.in_a, bus.in_b, bus.in_sub, cyc + 1 + WORDS));
         end else if (cyc >= pend[0].due && bus.out_ready) begin
            heldSum  = pend[0].sum;
            heldCout = pend[0].cout;
            heldOvf  = pend[0].ovf;
            void'(pend.pop_front());
         end
      end
      cyc++;
   end

   // Compare process: DUT outputs against the model on every falling edge.
   always @(negedge Clk) begin
      if (armed) begin
         mIdle = (pend.size() == 0);
         mDue  = !mIdle && (cyc >= pend[0].due);
         check("m_in_ready",  W'(bus.in_ready),  W'(mIdle));
         check("m_busy",      W'(bus.busy),      W'(!mIdle));
         check("m_out_valid", W'(bus.out_valid), W'(mDue));
         if (mIdle) begin
            check("m_held_sum",  bus.out_sum,       heldSum);
            check("m_held_cout", W'(bus.out_cout),  W'(heldCout));
            check("m_held_ovf",  W'(bus.out_ovf),   W'(heldOvf));
         end else if (mDue) begin
            check("m_sum",  bus.out_sum,      pend[0].sum);
            check("m_cout", W'(bus.out_cout), W'(pend[0].cout));
            check("m_ovf",  W'(bus.out_ovf),  W'(pend[0].ovf));
         end
      end
   end

   task automatic applyReq(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      @(negedge Clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
      check("accept_ready", W'(bus.in_ready), W'(1));
      @(posedge Clk);
   endtask

   // Called right after the acceptance edge; returns at the first negedge with out_valid.
   task automatic waitResult(input string name, input logic [W-1:0] eSum,
                             input logic eCout, input logic eOvf);
      int edges = 0;
      bit got   = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge Clk);
         bus.in_valid = 1'b0;
         if (bus.out_valid) got = 1'b1;
         else               edges++;
      end
      check({name, "_latency"}, W'(edges), W'(WORDS));
      check({name, "_sum"},  bus.out_sum,      eSum);
      check({name, "_cout"}, W'(bus.out_cout), W'(eCout));
      check({name, "_ovf"},  W'(bus.out_ovf),  W'(eOvf));
   endtask

   task automatic ackResult(input string name);
      bus.out_ready = 1'b1;
      @(negedge Clk);
      bus.out_ready = 1'b0;
      check({name, "_valid_drop"}, W'(bus.out_valid), W'(0));
   endtask

   task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] eSum, input logic eCout,
                        input logic eOvf);
      applyReq(a, b, sub);
      waitResult(name, eSum, eCout, eOvf);
      ackResult(name);
   endtask

   function automatic logic [W-1:0] randWord();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '1;
         1:       v = {1'b1, {(W-1){1'b0}}};
         2:       v = {1'b0, {(W-1){1'b1}}};
         3:       v = W'(1);
         default: for (int k = 0; k < W; k += 16) v[k +: 16] = 16'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sub    = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_in_ready",  W'(bus.in_ready),  W'(1));
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_out_sum",   bus.out_sum,       W'(0));
      check("rst_out_cout",  W'(bus.out_cout),  W'(0));
      check("rst_out_ovf",   W'(bus.out_ovf),   W'(0));
      check("rst_busy",      W'(bus.busy),      W'(0));
      Reset_n = 1'b1;

      runOp("add_carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
            64'h0000_0000_0001_0000, 1'b0, 1'b0);
      runOp("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
      runOp("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1);
      runOp("sub_borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      runOp("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // Backpressure: result held for 10 cycles while a new request waits.
      applyReq(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0);
      waitResult("bp", 64'h0000_0001_0000_0000, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_a     = 64'h1;
      bus.in_b     = 64'h1;
      bus.in_sub   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         check("bp_hold_valid", W'(bus.out_valid), W'(1));
         check("bp_hold_ready", W'(bus.in_ready),  W'(0));
         check("bp_hold_sum",   bus.out_sum,       64'h0000_0001_0000_0000);
         check("bp_hold_cout",  W'(bus.out_cout),  W'(1));
      end
      bus.in_a      = 64'h1234_5678_9ABC_DEF0;
      bus.in_b      = 64'h0FED_CBA9_8765_4321;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge Clk);
      bus.out_ready = 1'b0;
      check("bp_idle_ready", W'(bus.in_ready),  W'(1));
      check("bp_idle_valid", W'(bus.out_valid), W'(0));
      @(posedge Clk);
      waitResult("bp_pending", 64'h2222_2222_2222_2211, 1'b0, 1'b0);
      ackResult("bp_pending");

      // Reset on the second RUN cycle discards the operation.
      applyReq(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      @(negedge Clk);
      bus.in_valid = 1'b0;
      @(negedge Clk);
      check("midrst_busy_before", W'(bus.busy), W'(1));
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      check("midrst_in_ready",  W'(bus.in_ready),  W'(1));
      check("midrst_out_valid", W'(bus.out_valid), W'(0));
      check("midrst_out_sum",   bus.out_sum,       W'(0));
      check("midrst_busy",      W'(bus.busy),      W'(0));
      runOp("after_rst", 64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0);

      // Reset and request in the same cycle: reset wins.
      @(negedge Clk);
      bus.in_a     = 64'h9;
      bus.in_b     = 64'h9;
      bus.in_valid = 1'b1;
      Reset_n      = 1'b0;
      @(negedge Clk);
      Reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      Reset_n      = 1'b1;
      check("rstwin_busy",  W'(bus.busy),     W'(0));
      check("rstwin_ready", W'(bus.in_ready), W'(1));
      @(negedge Clk);
      check("rstwin_still_idle", W'(bus.busy), W'(0));

      // Random traffic with random backpressure, checked by the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge Clk);
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_sub    = 1'($urandom_range(0, 1));
         bus.in_a      = randWord();
         bus.in_b      = randWord();
         bus.out_ready = ($urandom_range(0, 1) == 1);
      end

      @(negedge Clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 64 && (pend.size() != 0 || bus.busy); i++) @(negedge Clk);
      check("drain_empty", W'(pend.size()), W'(0));
      check("drain_busy",  W'(bus.busy),    W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end
endmodule
